pll_seq_ctrl: RTL and testbench

PLL_SEQ_CTRL -- requirements
Module: pll_seq_ctrl

---
 rtl/pll_seq_pkg.sv | 33 +++
 rtl/lock_sync.sv | 27 ++
 rtl/pll_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pll_seq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL start-up / reconfiguration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

    // Width of each Gowin dynamic divider select (FBDSEL/IDSEL/ODSEL)
    localparam int SEL_W   = 6;
    // Lock-timeout retry counter width
    localparam int RETRY_W = 2;
    // Lock-loss event counter width (saturating)
    localparam int LOST_W  = 8;
    // Shared phase cycle counter; wide enough for multi-millisecond timeouts
    localparam int CNT_W   = 32;
    // Width of the exported state code
    localparam int STATE_W = 3;

    // Encodings are visible on the state output, so they are fixed here
    typedef enum logic [STATE_W-1:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
        logic [LOST_W-1:0] r;
        r = (v == {LOST_W{1'b1}}) ? v : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the PLL LOCK flag into the reference domain.
// Latency: output follows input after 2 clock edges.
// Backpressure: none; free-running.
module lock_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Metastability stage followed by the clean output stage; both cleared on reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL sequencer: reset pulse, lock wait with retries, stability qualification, run, fault, reconfiguration.
// Latency: all outputs registered; state and status change on the edge that takes the decision.
// Backpressure: cfg_req is held off (no cfg_ack) outside RUN and FAULT; accepted requests ack one cycle.
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int unsigned      PLL_RST_CYC      = 16,
    parameter int unsigned      LOCK_TIMEOUT_CYC = 270000,
    parameter int unsigned      LOCK_STABLE_CYC  = 1024,
    parameter int unsigned      MAX_RETRY        = 3,
    parameter logic [SEL_W-1:0] DEF_FBDSEL       = '0,
    parameter logic [SEL_W-1:0] DEF_IDSEL        = '0,
    parameter logic [SEL_W-1:0] DEF_ODSEL        = '0
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                pll_lock,
    input  logic                cfg_req,
    input  logic [SEL_W-1:0]    cfg_fbdsel,
    input  logic [SEL_W-1:0]    cfg_idsel,
    input  logic [SEL_W-1:0]    cfg_odsel,
    output logic                cfg_ack,
    output logic                pll_reset,
    output logic [SEL_W-1:0]    pll_fbdsel,
    output logic [SEL_W-1:0]    pll_idsel,
    output logic [SEL_W-1:0]    pll_odsel,
    output logic                sys_rst,
    output logic                fault,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic [LOST_W-1:0]   lost_cnt,
    output logic [STATE_W-1:0]  state
);

    // Terminal counts: each phase ends on the edge where the counter reaches N-1
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    pll_state_t         r_state;
    pll_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [LOST_W-1:0]  r_lost;
    logic [LOST_W-1:0]  w_lost_nxt;
    logic               w_accept;
    logic               w_lock_s;

    logic               r_cfg_ack;
    logic               r_pll_reset;
    logic               r_sys_rst;
    logic               r_fault;
    logic [SEL_W-1:0]   r_fbdsel;
    logic [SEL_W-1:0]   r_idsel;
    logic [SEL_W-1:0]   r_odsel;

    lock_sync u_lock_sync (
        .i_clk   (clkin),
        .i_rst   (reset),
        .i_async (pll_lock),
        .o_sync  (w_lock_s)
    );

    // State register plus the counters that travel with it
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state <= ST_RST_PLL;
            r_cnt   <= '0;
            r_retry <= '0;
            r_lost  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            r_lost  <= w_lost_nxt;
        end
    end

    // Next-state decision; r_cnt is a per-phase cycle counter cleared on every transition
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_lost_nxt  = r_lost;
        w_accept    = 1'b0;

        case (r_state)
            ST_RST_PLL: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TMO_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retry >= RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = ST_RST_PLL;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_STABLE: begin
                // Any dropout restarts qualification from the lock wait
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STB_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                // Loss is still counted when a request lands in the same cycle
                if (!w_lock_s) begin
                    w_lost_nxt  = sat_inc(r_lost);
                    w_state_nxt = ST_RST_PLL;
                    w_cnt_nxt   = '0;
                end
                if (cfg_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RST_PLL;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end

            ST_FAULT: begin
                // Parked with the PLL in reset until software supplies new selects
                if (cfg_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RST_PLL;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_RST_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Registered outputs derived from the next state so they move with the state register
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_cfg_ack   <= 1'b0;
            r_pll_reset <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_fault     <= 1'b0;
        end else begin
            r_cfg_ack   <= w_accept;
            r_pll_reset <= (w_state_nxt == ST_RST_PLL) || (w_state_nxt == ST_FAULT);
            r_sys_rst   <= (w_state_nxt != ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAULT);
        end
    end

    // Divider selects: load defaults on reset, otherwise only on an accepted request
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_fbdsel <= DEF_FBDSEL;
            r_idsel  <= DEF_IDSEL;
            r_odsel  <= DEF_ODSEL;
        end else if (w_accept) begin
            r_fbdsel <= cfg_fbdsel;
            r_idsel  <= cfg_idsel;
            r_odsel  <= cfg_odsel;
        end
    end

    assign cfg_ack    = r_cfg_ack;
    assign pll_reset  = r_pll_reset;
    assign sys_rst    = r_sys_rst;
    assign fault      = r_fault;
    assign pll_fbdsel = r_fbdsel;
    assign pll_idsel  = r_idsel;
    assign pll_odsel  = r_odsel;
    assign retry_cnt  = r_retry;
    assign lost_cnt   = r_lost;
    assign state      = r_state;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl: directed scenarios then random lock/request traffic.
// Expected outputs come from a timeline model; a monitor compares every cycle.
// Inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
module tb_pll_seq_ctrl;

    localparam int RST_C = 4;
    localparam int TMO_C = 50;
    localparam int STB_C = 8;
    localparam int MAXR  = 2;
    localparam logic [5:0] DFB = 6'h11;
    localparam logic [5:0] DID = 6'h03;
    localparam logic [5:0] DOD = 6'h08;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_fbdsel = '0;
    logic [5:0] cfg_idsel = '0;
    logic [5:0] cfg_odsel = '0;
    logic       cfg_ack;
    logic       pll_reset;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_idsel;
    logic [5:0] pll_odsel;
    logic       sys_rst;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    pll_seq_ctrl #(
        .PLL_RST_CYC      (RST_C),
        .LOCK_TIMEOUT_CYC (TMO_C),
        .LOCK_STABLE_CYC  (STB_C),
        .MAX_RETRY        (MAXR),
        .DEF_FBDSEL       (DFB),
        .DEF_IDSEL        (DID),
        .DEF_ODSEL        (DOD)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .cfg_req    (cfg_req),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_idsel  (cfg_idsel),
        .cfg_odsel  (cfg_odsel),
        .cfg_ack    (cfg_ack),
        .pll_reset  (pll_reset),
        .pll_fbdsel (pll_fbdsel),
        .pll_idsel  (pll_idsel),
        .pll_odsel  (pll_odsel),
        .sys_rst    (sys_rst),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .lost_cnt   (lost_cnt),
        .state      (state)
    );

    always #5 clkin = ~clkin;

    // ---------------- reference model ----------------
    // phase: 0 reset pulse, 1 lock wait, 2 qualification, 3 run, 4 fault
    // lock_hist holds raw lock samples; the controller acts on the one taken two edges ago
    int   m_phase = 0;
    int   m_elapsed = 0;
    int   m_retry = 0;
    int   m_lost = 0;
    int   m_fb = DFB, m_id = DID, m_od = DOD;
    bit   m_ack = 0;
    bit   lock_hist[$];

    logic [34:0] exp_q[$];

    function automatic logic [34:0] pack(logic [2:0] st, logic pr, logic sr, logic ak, logic ft,
                                         logic [1:0] rc, logic [7:0] lc,
                                         logic [5:0] fb, logic [5:0] id, logic [5:0] od);
        return {st, pr, sr, ak, ft, rc, lc, fb, id, od};
    endfunction

    task automatic model_accept(input logic [5:0] fb, input logic [5:0] id, input logic [5:0] od);
        m_ack = 1;
        m_fb = fb; m_id = id; m_od = od;
        m_retry = 0;
        m_phase = 0;
        m_elapsed = 0;
    endtask

    task automatic model_step(input logic rst, input logic lock, input logic req,
                              input logic [5:0] fb, input logic [5:0] id, input logic [5:0] od);
        bit seen;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_retry = 0; m_lost = 0; m_ack = 0;
            m_fb = DFB; m_id = DID; m_od = DOD;
            lock_hist = '{0, 0};
        end else begin
            seen = lock_hist.pop_front();
            lock_hist.push_back(lock);
            m_ack = 0;
            case (m_phase)
                0: begin
                    m_elapsed++;
                    if (m_elapsed >= RST_C) begin m_phase = 1; m_elapsed = 0; end
                end
                1: begin
                    if (seen) begin
                        m_phase = 2; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed >= TMO_C) begin
                            m_elapsed = 0;
                            if (m_retry < MAXR) begin m_retry++; m_phase = 0; end
                            else m_phase = 4;
                        end
                    end
                end
                2: begin
                    if (!seen) begin
                        m_phase = 1; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed >= STB_C) begin m_phase = 3; m_elapsed = 0; m_retry = 0; end
                    end
                end
                3: begin
                    if (!seen) begin
                        m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                        m_phase = 0; m_elapsed = 0;
                    end
                    if (req) model_accept(fb, id, od);
                end
                default: begin
                    if (req) model_accept(fb, id, od);
                end
            endcase
        end
    endtask

    function automatic logic [34:0] model_out();
        return pack(3'(m_phase), (m_phase == 0 || m_phase == 4), (m_phase != 3), m_ack,
                    (m_phase == 4), 2'(m_retry), 8'(m_lost), 6'(m_fb), 6'(m_id), 6'(m_od));
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [34:0] e, g;
        forever begin
            @(posedge clkin);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = pack(state, pll_reset, sys_rst, cfg_ack, fault, retry_cnt, lost_cnt,
                         pll_fbdsel, pll_idsel, pll_odsel);
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got st=%0d prst=%0b srst=%0b ack=%0b flt=%0b rty=%0d lost=%0d sel=%h/%h/%h exp st=%0d prst=%0b srst=%0b ack=%0b flt=%0b rty=%0d lost=%0d sel=%h/%h/%h",
                             $time, g[34:32], g[31], g[30], g[29], g[28], g[27:26], g[25:18], g[17:12], g[11:6], g[5:0],
                             e[34:32], e[31], e[30], e[29], e[28], e[27:26], e[25:18], e[17:12], e[11:6], e[5:0]);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input logic rst, input logic lock, input logic req,
                        input logic [5:0] fb, input logic [5:0] id, input logic [5:0] od);
        @(negedge clkin);
        reset = rst; pll_lock = lock; cfg_req = req;
        cfg_fbdsel = fb; cfg_idsel = id; cfg_odsel = od;
        model_step(rst, lock, req, fb, id, od);
        exp_q.push_back(model_out());
        @(posedge clkin);
        #1;
    endtask

    task automatic step_l(input logic lock);
        step(1'b0, lock, 1'b0, 6'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic wait_state(input int st, input int lim, input logic lock);
        int n = 0;
        while (int'(state) != st && n < lim) begin
            step_l(lock);
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fall, plow, zeros, first_run, acks, prst_hi, rises, max_rty;
        bit saw1, prev_pr;
        logic [5:0] rf, ri, ro;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 6'h3F, 6'h3F, 6'h3F);
        chk("reset_state", int'(state), 0);
        chk("reset_pll_reset", int'(pll_reset), 1);
        chk("reset_sys_rst", int'(sys_rst), 1);
        chk("reset_fbdsel", int'(pll_fbdsel), int'(DFB));

        // Nominal bring-up: lock appears at cycle 10
        fall = -1; plow = -1;
        for (int k = 0; k < 40; k++) begin
            step_l(k >= 10);
            if (pll_reset == 1'b0 && plow < 0) plow = k;
            if (sys_rst == 1'b0 && fall < 0) fall = k;
        end
        chk_rng("nominal_pll_reset_low", plow, 3, 4);
        chk_rng("nominal_sys_rst_fall", fall, 10 + 2 + STB_C - 1, 10 + 2 + STB_C + 1);
        chk("nominal_run", int'(state), 3);

        // Lock loss in RUN, then a 3-cycle glitch while re-qualifying
        zeros = 0; first_run = -1;
        for (int k = 0; k < 40; k++) begin
            step_l(!(k == 0 || (k >= 9 && k <= 11)));
            if (k == 1) chk("loss_sys_rst_still_low", int'(sys_rst), 0);
            if (k == 2) chk("loss_sys_rst_3cyc", int'(sys_rst), 1);
            if (k >= 3 && k <= 20 && sys_rst == 1'b0) zeros++;
            if (k >= 3 && state == 3'd3 && first_run < 0) first_run = k;
        end
        chk("glitch_sys_rst_held", zeros, 0);
        chk_rng("glitch_rerun_cycle", first_run, 21, 23);
        chk("loss_lost_cnt", int'(lost_cnt), 1);

        // Reconfiguration from RUN
        rf = 6'h2A; ri = 6'($urandom); ro = 6'($urandom);
        acks = 0; prst_hi = 0;
        step(1'b0, 1'b1, 1'b1, rf, ri, ro);
        acks += int'(cfg_ack); prst_hi += int'(pll_reset);
        for (int k = 0; k < 29; k++) begin
            step_l(1'b1);
            acks += int'(cfg_ack); prst_hi += int'(pll_reset);
        end
        chk("reconfig_ack_pulses", acks, 1);
        chk("reconfig_pll_reset_len", prst_hi, RST_C);
        chk("reconfig_fbdsel", int'(pll_fbdsel), 'h2A);
        chk("reconfig_idsel", int'(pll_idsel), int'(ri));
        chk("reconfig_rerun", int'(state), 3);

        // Lock never returns: retries then fault
        rises = 0; max_rty = 0; saw1 = 0; prev_pr = pll_reset;
        for (int k = 0; k < 400 && fault == 1'b0; k++) begin
            step_l(1'b0);
            if (fault == 1'b0 && pll_reset && !prev_pr) rises++;
            prev_pr = pll_reset;
            if (retry_cnt == 2'd1) saw1 = 1;
            if (int'(retry_cnt) > max_rty) max_rty = int'(retry_cnt);
        end
        chk("timeout_pulses", rises, MAXR + 1);
        chk("timeout_saw_retry1", int'(saw1), 1);
        chk("timeout_max_retry", max_rty, MAXR);
        chk("timeout_fault", int'(fault), 1);
        chk("timeout_state", int'(state), 4);
        repeat (5) step_l(1'b1);
        chk("fault_holds_pll_reset", int'(pll_reset), 1);

        // Reconfiguration out of FAULT
        rf = 6'($urandom); ri = 6'($urandom); ro = 6'($urandom);
        step(1'b0, 1'b0, 1'b1, rf, ri, ro);
        chk("fault_cfg_ack", int'(cfg_ack), 1);
        chk("fault_cfg_state", int'(state), 0);
        chk("fault_cfg_fault_clr", int'(fault), 0);
        chk("fault_cfg_odsel", int'(pll_odsel), int'(ro));

        // Reset during WAIT_LOCK restores default selects
        wait_state(1, 20, 1'b0);
        chk("reach_wait_lock", int'(state), 1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 6'($urandom), 6'($urandom), 6'($urandom));
        chk("midreset_state", int'(state), 0);
        chk("midreset_fbdsel", int'(pll_fbdsel), int'(DFB));
        chk("midreset_odsel", int'(pll_odsel), int'(DOD));
        chk("midreset_lost", int'(lost_cnt), 0);

        // Many lock losses: lost_cnt saturates
        for (int i = 0; i < 260; i++) begin
            wait_state(3, 40, 1'b1);
            step_l(1'b0);
            repeat (3) step_l(1'b1);
        end
        chk("lost_cnt_saturates", int'(lost_cnt), 255);

        // Random traffic
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, 1'b0, 6'($urandom), 6'($urandom), 6'($urandom));
            end else begin
                bit lvl;
                int len;
                lvl = ($urandom_range(0, 3) != 0);
                len = $urandom_range(1, 60);
                for (int k = 0; k < len; k++)
                    step(1'b0, lvl, ($urandom_range(0, 15) == 0), 6'($urandom), 6'($urandom), 6'($urandom));
            end
        end

        repeat (2) @(posedge clkin);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
